// File: rtl/cell_instruction_issuer.sv
// -----------------------------------------------------------------------------
// cell_instruction_issuer
//
// Producer side of the cell-processing interface. Two lockstep raster pixel
// streams (image A and image B) are turned into 3x3 neighbourhood matrices
// with per-stream line buffers. One instruction word is issued per interior
// centre pixel through a single-entry valid/ready output slot. The opcode and
// user immediate are latched at start and held for the whole frame.
//
// Parameters
//   IMG_WIDTH   pixels per line (>= 3)
//   IMG_HEIGHT  lines per frame (>= 3)
//   DATA_W      pixel width
//   OP_W        opcode width
//
// Ports
//   clk         single clock, rising edge
//   rst         asynchronous active-high reset
//   start       begin a frame (honoured only in IDLE)
//   opcode_in   opcode for every instruction of the frame
//   user_in     immediate placed in userInputA
//   pix_valid   pixA/pixB valid
//   pix_ready   issuer accepts a pixel pair this cycle
//   pixA, pixB  raster-order pixels at the same (x,y)
//   iw_valid    IW holds a complete instruction
//   iw_ready    downstream consumes IW
//   IW          instruction word, packed MSB->LSB as:
//                 opcode[OP_W], cellA[0..2][0..2], cellB[0..2][0..2],
//                 userInputA[DATA_W]; matrix element [r][c] is the pixel at
//                 (cx-1+c, cy-1+r), [0][0] is the most significant element.
//   busy        state != IDLE
//   frame_done  one-cycle pulse in the DONE state
// -----------------------------------------------------------------------------
module cell_instruction_issuer #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64,
  parameter int DATA_W     = 8,
  parameter int OP_W       = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [OP_W-1:0]              opcode_in,
  input  logic [DATA_W-1:0]            user_in,
  input  logic                         pix_valid,
  output logic                         pix_ready,
  input  logic [DATA_W-1:0]            pixA,
  input  logic [DATA_W-1:0]            pixB,
  output logic                         iw_valid,
  input  logic                         iw_ready,
  output logic [OP_W+19*DATA_W-1:0]    IW,
  output logic                         busy,
  output logic                         frame_done
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef logic [DATA_W-1:0] pix_t;
  typedef pix_t [0:2][0:2]   win_t;

  typedef struct packed {
    logic [OP_W-1:0] opcode;
    win_t            cellA;
    win_t            cellB;
    pix_t            userInputA;
  } instr_t;

  // Control state
  logic [1:0]      r_state;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic [OP_W-1:0] r_opcode;
  pix_t            r_user;

  // Line buffers: *_l1 holds line y-1, *_l2 holds line y-2
  pix_t r_lb_a_l1 [IMG_WIDTH];
  pix_t r_lb_a_l2 [IMG_WIDTH];
  pix_t r_lb_b_l1 [IMG_WIDTH];
  pix_t r_lb_b_l2 [IMG_WIDTH];

  // Window stage and output slot
  win_t   r_win_a_p0;
  win_t   r_win_b_p0;
  win_t   w_win_a_nxt;
  win_t   w_win_b_nxt;
  instr_t r_iw_p1;
  logic   r_iw_vld_p1;

  logic w_pix_ready;
  logic w_accept;
  logic w_emit;
  logic w_last_x;
  logic w_last_pix;

  // Shift the window one column left and insert the new column on the right.
  function automatic win_t shift_in(input win_t w, input pix_t top,
                                    input pix_t mid, input pix_t bot);
    win_t n;
    for (int r = 0; r < 3; r++) begin
      n[r][0] = w[r][1];
      n[r][1] = w[r][2];
    end
    n[0][2] = top;
    n[1][2] = mid;
    n[2][2] = bot;
    return n;
  endfunction

  // A stalled slot back-pressures the pixel input, so IW never has to be
  // overwritten while the consumer has not taken it.
  assign w_pix_ready = (r_state == S_RUN) && (!r_iw_vld_p1 || iw_ready);
  assign w_accept    = pix_valid && w_pix_ready;
  assign w_last_x    = (r_x == XW'(IMG_WIDTH - 1));
  assign w_last_pix  = w_last_x && (r_y == YW'(IMG_HEIGHT - 1));

  // The accepted pixel completes a full 3x3 window only once two columns and
  // two lines precede it; the centre then lags by one in each direction.
  assign w_emit = w_accept && (r_x >= XW'(2)) && (r_y >= YW'(2));

  assign w_win_a_nxt = shift_in(r_win_a_p0, r_lb_a_l2[r_x], r_lb_a_l1[r_x], pixA);
  assign w_win_b_nxt = shift_in(r_win_b_p0, r_lb_b_l2[r_x], r_lb_b_l1[r_x], pixB);

  // ---- Stage p0: frame control, position counters, configuration latch ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_x      <= '0;
      r_y      <= '0;
      r_opcode <= '0;
      r_user   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state  <= S_RUN;
            r_opcode <= opcode_in;
            r_user   <= user_in;
            r_x      <= '0;
            r_y      <= '0;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            if (w_last_pix) begin
              r_state <= S_FLUSH;
              r_x     <= '0;
              r_y     <= '0;
            end else if (w_last_x) begin
              r_x <= '0;
              r_y <= r_y + YW'(1);
            end else begin
              r_x <= r_x + XW'(1);
            end
          end
        end
        S_FLUSH: begin
          // Leave once the final instruction is gone or leaving right now.
          if (!r_iw_vld_p1 || iw_ready) begin
            r_state <= S_DONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // ---- Stage p0: line buffers and 3x3 windows (data only, no reset) ----
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb_a_l2[r_x] <= r_lb_a_l1[r_x];
      r_lb_a_l1[r_x] <= pixA;
      r_lb_b_l2[r_x] <= r_lb_b_l1[r_x];
      r_lb_b_l1[r_x] <= pixB;
      r_win_a_p0     <= w_win_a_nxt;
      r_win_b_p0     <= w_win_b_nxt;
    end
  end

  // ---- Stage p1: single-entry output slot ----
  // IW is part of the defined reset state, so the slot data is reset too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_iw_vld_p1 <= 1'b0;
      r_iw_p1     <= '0;
    end else if (w_emit) begin
      r_iw_vld_p1        <= 1'b1;
      r_iw_p1.opcode     <= r_opcode;
      r_iw_p1.cellA      <= w_win_a_nxt;
      r_iw_p1.cellB      <= w_win_b_nxt;
      r_iw_p1.userInputA <= r_user;
    end else if (iw_ready) begin
      r_iw_vld_p1 <= 1'b0;
    end
  end

  assign pix_ready  = w_pix_ready;
  assign iw_valid   = r_iw_vld_p1;
  assign IW         = r_iw_p1;
  assign busy       = (r_state != S_IDLE);
  assign frame_done = (r_state == S_DONE);

endmodule
